// File: rtl/vector_point_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : vector_point_sequencer                                         |
// | Purpose : Point FIFO and sequencer feeding a Bresenham line stepper.     |
// |           Buffers (x, y, blank) points, issues one load strobe per       |
// |           point, waits for the stepper to arrive, holds a per-point      |
// |           dwell, and drives the beam enable (lit draw / blank move).     |
// | Ports   : clk, reset        clock, synchronous active-high reset         |
// |           in_valid/in_ready source handshake, in_x/in_y/in_blank point   |
// |           lt_strobe         one-cycle load pulse to the stepper          |
// |           lt_x/lt_y         registered stepper destination               |
// |           lt_ready          stepper has reached its destination          |
// |           beam_on           beam/Z enable to the intensity DAC           |
// |           busy, level       activity flag and FIFO occupancy             |
// | Config  : VECTOR_SEQ_DUPSKIP_EN - when defined, a head point identical   |
// |           to the last issued point is discarded without a strobe.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module vector_point_sequencer #(
  parameter int BITS        = 12,
  parameter int DEPTH_LOG2  = 4,
  parameter int DWELL       = 8,
  parameter int BLANK_DWELL = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_x,
  input  logic [BITS-1:0]       in_y,
  input  logic                  in_blank,
  output logic                  lt_strobe,
  output logic [BITS-1:0]       lt_x,
  output logic [BITS-1:0]       lt_y,
  input  logic                  lt_ready,
  output logic                  beam_on,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int C_DEPTH   = 1 << DEPTH_LOG2;
  localparam int C_MAX_DW  = (DWELL > BLANK_DWELL) ? DWELL : BLANK_DWELL;
  localparam int C_CNT_W   = $clog2(C_MAX_DW + 1);

  localparam logic [DEPTH_LOG2:0] c_full        = (DEPTH_LOG2+1)'(C_DEPTH);
  localparam logic [C_CNT_W-1:0]  c_dwell       = C_CNT_W'(DWELL);
  localparam logic [C_CNT_W-1:0]  c_blank_dwell = C_CNT_W'(BLANK_DWELL);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_DRAW   = 3'd3,
    S_DWELL  = 3'd4
  } state_t;

  // ---------------------------------------------------------------- FIFO
  // Entry layout: {blank, y, x}
  logic [2*BITS:0]         r_mem [0:C_DEPTH-1];
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_level;

  state_t                  r_state;
  logic                    r_cur_blank;
  logic [C_CNT_W-1:0]      r_cnt;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_dup;
  logic [2*BITS:0]         w_head;

  assign in_ready = (r_level != c_full);
  assign level    = r_level;
  assign busy     = (r_state != S_IDLE) || (r_level != '0);

  assign w_push = in_valid && in_ready;
  // The only consumer is the IDLE state; discarded duplicates also pop.
  assign w_pop  = (r_state == S_IDLE) && (r_level != '0);
  assign w_head = r_mem[r_rd_ptr];

`ifdef VECTOR_SEQ_DUPSKIP_EN
  // lt_x/lt_y/r_cur_blank always hold the last issued point, so they double
  // as the duplicate reference; r_last_vld forces the first point after reset
  // to be issued even if it happens to match the reset values.
  logic r_last_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_vld <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_last_vld <= 1'b1;
    end
  end

  assign w_dup = r_last_vld && (w_head == {r_cur_blank, lt_y, lt_x});
`else
  assign w_dup = 1'b0;
`endif

  // Storage carries no reset: entries are only read below the level count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_blank, in_y, in_x};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      lt_strobe   <= 1'b0;
      lt_x        <= '0;
      lt_y        <= '0;
      r_cur_blank <= 1'b0;
      beam_on     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      lt_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop && !w_dup) begin
            lt_x        <= w_head[BITS-1:0];
            lt_y        <= w_head[2*BITS-1:BITS];
            r_cur_blank <= w_head[2*BITS];
            // Registered strobe is high exactly while the FSM sits in ISSUE.
            lt_strobe   <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          beam_on <= !r_cur_blank;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          // Gives the stepper a cycle to drop lt_ready for the new target.
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          if (lt_ready) begin
            r_cnt   <= r_cur_blank ? c_blank_dwell : c_dwell;
            r_state <= S_DWELL;
          end
        end
        S_DWELL: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == C_CNT_W'(1)) begin
            r_state <= S_IDLE;
            // Never leave the beam parked lit while starved of points.
            if (r_level == '0) begin
              beam_on <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_point_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_vector_point_sequencer                                      |
// | Purpose : Self-checking bench for vector_point_sequencer. Expected       |
// |           points are queued as they are pushed and checked at each       |
// |           lt_strobe; scenario tasks check timing, flow control, reset.   |
// |           Honours VECTOR_SEQ_DUPSKIP_EN for duplicate expectations.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vector_point_sequencer;

  localparam int BITS  = 12;
  localparam int DL    = 4;
  localparam int DW    = 8;
  localparam int BDW   = 16;

  typedef struct packed {
    logic            b;
    logic [BITS-1:0] y;
    logic [BITS-1:0] x;
  } pt_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] in_x = '0;
  logic [BITS-1:0] in_y = '0;
  logic            in_blank = 1'b0;
  logic            lt_strobe;
  logic [BITS-1:0] lt_x;
  logic [BITS-1:0] lt_y;
  logic            lt_ready = 1'b1;
  logic            beam_on;
  logic            busy;
  logic [DL:0]     level;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   strobes = 0;
  pt_t  exp_q[$];
  int   strobe_cyc[$];
  pt_t  last_pt;
  bit   last_vld = 1'b0;
  logic beam_chk = 1'b0;
  logic beam_exp = 1'b0;
  pt_t  mon_e;

  vector_point_sequencer #(
    .BITS(BITS), .DEPTH_LOG2(DL), .DWELL(DW), .BLANK_DWELL(BDW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_blank(in_blank),
    .lt_strobe(lt_strobe), .lt_x(lt_x), .lt_y(lt_y), .lt_ready(lt_ready),
    .beam_on(beam_on), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: pops the scoreboard, checks destination, then checks the
  // beam state on the following cycle.
  always @(negedge clk) begin
    if (reset) begin
      beam_chk = 1'b0;
    end else begin
      if (beam_chk) begin
        total++;
        if (beam_on !== beam_exp) begin
          bad++;
          $display("FAIL beam_after_issue: got %b want %b", beam_on, beam_exp);
        end
        beam_chk = 1'b0;
      end
      if (lt_strobe === 1'b1) begin
        strobes++;
        strobe_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL strobe_unexpected: got (%0d,%0d) want none", lt_x, lt_y);
        end else begin
          mon_e = exp_q.pop_front();
          if (lt_x !== mon_e.x || lt_y !== mon_e.y) begin
            bad++;
            $display("FAIL strobe_point: got (%0d,%0d) want (%0d,%0d)",
                     lt_x, lt_y, mon_e.x, mon_e.y);
          end
          beam_exp = !mon_e.b;
          beam_chk = 1'b1;
        end
      end
    end
  end

  // Called just after a negedge; returns just after a negedge.
  task automatic push(input int x, input int y, input bit b);
    bit  ok;
    pt_t p;
    in_x = BITS'(x);
    in_y = BITS'(y);
    in_blank = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=%b want 1", in_ready);
    end else begin
      p.x = BITS'(x);
      p.y = BITS'(y);
      p.b = b;
`ifdef VECTOR_SEQ_DUPSKIP_EN
      if (!(last_vld && p == last_pt)) exp_q.push_back(p);
`else
      exp_q.push_back(p);
`endif
      last_pt = p;
      last_vld = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      done = (busy === 1'b0);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL idle_timeout: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total += 7;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    if (lt_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe: got %b want 0", lt_strobe); end
    if (lt_x !== '0)        begin bad++; $display("FAIL rst_lt_x: got %0d want 0", lt_x); end
    if (lt_y !== '0)        begin bad++; $display("FAIL rst_lt_y: got %0d want 0", lt_y); end
    if (beam_on !== 1'b0)   begin bad++; $display("FAIL rst_beam: got %b want 0", beam_on); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (level !== '0)       begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
  endtask

  // Two lit points back to back with a zero-length stepper: strobe distance
  // is ISSUE+SETTLE+DRAW+DWELL+IDLE = DW+4 edges (5+DW cycles counting both).
  task automatic test_lit_spacing();
    lt_ready = 1'b1;
    strobe_cyc.delete();
    push(100, 200, 1'b0);
    push(101, 201, 1'b0);
    wait_idle(200);
    total += 2;
    if (strobe_cyc.size() != 2) begin
      bad++;
      $display("FAIL lit_strobe_count: got %0d want 2", strobe_cyc.size());
    end else if (strobe_cyc[1] - strobe_cyc[0] != DW + 4) begin
      bad++;
      $display("FAIL lit_spacing: got %0d want %0d", strobe_cyc[1] - strobe_cyc[0], DW + 4);
    end
    if (beam_on !== 1'b0) begin
      bad++;
      $display("FAIL beam_starved: got %b want 0", beam_on);
    end
  endtask

  task automatic test_blank_then_lit();
    lt_ready = 1'b1;
    strobe_cyc.delete();
    push(0, 0, 1'b1);
    push(50, 50, 1'b0);
    wait_idle(200);
    total++;
    if (strobe_cyc.size() != 2) begin
      bad++;
      $display("FAIL blank_strobe_count: got %0d want 2", strobe_cyc.size());
    end else if (strobe_cyc[1] - strobe_cyc[0] != BDW + 4) begin
      bad++;
      $display("FAIL blank_spacing: got %0d want %0d", strobe_cyc[1] - strobe_cyc[0], BDW + 4);
    end
  endtask

  task automatic test_fill_drain();
    bit grew;
    int prev;
    lt_ready = 1'b0;
    // First point is popped into the stalled stepper; 16 more fill the FIFO.
    for (int i = 0; i < 17; i++) push(i * 3 + 1, i * 5 + 2, i[0]);
    total += 2;
    if (level !== 5'd16)   begin bad++; $display("FAIL full_level: got %0d want 16", level); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
    in_x = 12'd999;
    in_y = 12'd999;
    in_blank = 1'b0;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (level !== 5'd16) begin bad++; $display("FAIL full_reject: got %0d want 16", level); end
    lt_ready = 1'b1;
    grew = 1'b0;
    prev = int'(level);
    for (int n = 0; n < 1000 && busy === 1'b1; n++) begin
      @(negedge clk);
      if (int'(level) > prev) grew = 1'b1;
      prev = int'(level);
    end
    total += 3;
    if (grew)              begin bad++; $display("FAIL drain_monotonic: got rise want none"); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL drain_idle: got busy=%b want 0", busy); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain_leftover: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int s;
    lt_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(200 + i, 300 + i, 1'b0);
    repeat (3) @(negedge clk);
    total += 2;
    if (level !== 5'd3)   begin bad++; $display("FAIL mid_level: got %0d want 3", level); end
    if (beam_on !== 1'b1) begin bad++; $display("FAIL mid_beam: got %b want 1", beam_on); end
    reset = 1'b1;
    @(negedge clk);
    total += 4;
    if (level !== '0)       begin bad++; $display("FAIL rmid_level: got %0d want 0", level); end
    if (beam_on !== 1'b0)   begin bad++; $display("FAIL rmid_beam: got %b want 0", beam_on); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    if (lt_strobe !== 1'b0) begin bad++; $display("FAIL rmid_strobe: got %b want 0", lt_strobe); end
    reset = 1'b0;
    exp_q.delete();
    last_vld = 1'b0;
    lt_ready = 1'b1;
    s = strobes;
    repeat (30) @(negedge clk);
    total++;
    if (strobes != s) begin bad++; $display("FAIL rmid_no_strobe: got %0d want 0", strobes - s); end
  endtask

  task automatic test_dup();
    int s;
    int want;
`ifdef VECTOR_SEQ_DUPSKIP_EN
    want = 1;
`else
    want = 2;
`endif
    lt_ready = 1'b1;
    s = strobes;
    push(7, 7, 1'b0);
    push(7, 7, 1'b0);
    wait_idle(200);
    total++;
    if (strobes - s != want) begin
      bad++;
      $display("FAIL dup_strobes: got %0d want %0d", strobes - s, want);
    end
  endtask

  // Arrange a push in the very cycle IDLE pops the single queued entry.
  task automatic test_push_pop();
    lt_ready = 1'b0;
    push(300, 301, 1'b0);
    push(302, 303, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (level !== 5'd1) begin bad++; $display("FAIL pp_pre_level: got %0d want 1", level); end
    lt_ready = 1'b1;
    repeat (DW + 1) @(posedge clk);
    @(negedge clk);
    push(304, 305, 1'b0);
    total += 2;
    if (level !== 5'd1)     begin bad++; $display("FAIL pp_level: got %0d want 1", level); end
    if (lt_strobe !== 1'b1) begin bad++; $display("FAIL pp_issue: got %b want 1", lt_strobe); end
    wait_idle(200);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pp_leftover: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_lit_spacing();
    test_blank_then_lit();
    test_fill_drain();
    test_reset_mid();
    test_dup();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
